if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  SPARC-style fetch stage generalised from the fixed PC/nPC fetch path. Holds PC/nPC, reads a
//  parametrised instruction memory, and registers instruction+PC+valid into the IF/ID latch.
//  Adds stall, branch redirect through nPC (delayed-branch semantics), redirect capture during
//  stall, IF/ID flush and a runtime imem write port. Sits between the control unit and the ID stage.
// PARAMETERS
//  ADDR_W   32            PC/nPC width; addresses are bytes, word-aligned.
//  DEPTH    128           imem words; must be a power of 2. Index = pc[IDX_W+1:2], IDX_W=$clog2(DEPTH).
//  NOP_WORD 32'h0000_0000 word loaded into IF/ID on reset/flush/annul.
// PORTS
//  clk              in   1       clock, rising edge
//  R                in   1       reset: synchronous, active-high
//  LE               in   1       load enable: 1 = advance PC/nPC/IF-ID, 0 = stall (hold all)
//  redirect         in   1       taken branch/jump; the target enters nPC
//  redirect_target  in   ADDR_W  branch target; bits [1:0] ignored (forced 0)
//  flush            in   1       squash: IF/ID <= NOP, valid 0
//  imem_we          in   1       imem write strobe
//  imem_waddr       in   ADDR_W  imem byte address; word index as above
//  imem_wdata       in   32      imem write data
//  pc_out           out  ADDR_W  current fetch PC
//  npc_out          out  ADDR_W  current nPC
//  instruction_out  out  32      IF/ID instruction
//  pc_id_out        out  ADDR_W  IF/ID PC of instruction_out
//  valid_id_out     out  1       IF/ID valid
//  redir_pend_out   out  1       a redirect is captured and waiting for LE
// BEHAVIOUR
//  Reset (R=1 at posedge, dominates everything): pc=0, npc=4, instruction_out=NOP_WORD,
//   pc_id_out=0, valid_id_out=0, pending cleared. The imem array is not reset.
//  Fetch: combinational, word = Mem[pc index], wrapping modulo DEPTH (no fault).
//  Advance (LE=1): pc<=npc; npc<=tgt if redirect or pending else npc+4 (mod 2^ADDR_W).
//   tgt = redirect_target if redirect=1 this cycle, else the pending target.
//   IF/ID <= {word, pc, 1}. Pending cleared.
//  Delay slot: the instruction at the old nPC is always fetched after the branch; the target follows.
//  Stall (LE=0): pc, npc, IF/ID hold. redirect=1 during stall latches tgt and sets pending;
//   a later redirect overwrites the earlier one (newest wins).
//  flush=1: IF/ID <= {NOP_WORD, pc_id unchanged, 0}, even when LE=0. PC/nPC still follow LE.
//  Priority: R > flush (IF/ID) > LE; redirect affects only nPC/pending.
//  Latency: a word at pc appears on instruction_out one clock after the advancing edge.
//  imem write: committed at posedge when imem_we=1; a fetch of the same word in that cycle
//   returns the old data, and the next cycle returns the new data.
// CONFIGURATION
//  IF_ANNUL_EN defined: adds input `annul` (1). When annul=1 is sampled with redirect=0 on an
//   advancing edge (untaken annulling branch), the delay-slot word entering IF/ID is replaced by
//   NOP_WORD with valid 0. PC/nPC advance normally.
//  Not defined: no annul port. The delay slot always executes.
// STRUCTURE
//  Shared package if_pkg: NOP_WORD default, PC_RESET=0, NPC_RESET=4, pc_step=4 constant,
//   typedef ifid_t {instr, pc, valid}.
//  One sub-module: if_imem (DEPTH x 32, async read, sync write). The rest stays flat.
// TESTING
//  1 Reset, preload Mem[0..3]=A,B,C,D, LE=1 for 4 clk -> pc 0,4,8,12; instruction_out A,B,C; valid 1.
//  2 Branch at pc=4: redirect=1, tgt=0x40 -> next pc=8 (delay slot C), then pc=0x40; npc=0x44.
//  3 LE=0 for 3 clk with redirect pulsed to 0x80 in clk 1 -> outputs held, redir_pend_out=1;
//     LE=1 -> npc=0x80, pending clears.
//  4 flush=1 with LE=0 -> instruction_out=NOP_WORD, valid 0, pc unchanged; R mid-run -> pc=0, npc=4.
//  5 pc=4*DEPTH -> fetches Mem[0]; imem_we to current word -> old word this cycle, new word next.
//  6 (IF_ANNUL_EN) annul=1, redirect=0 at advance -> IF/ID=NOP, valid 0, pc still steps by 4.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and the IF/ID latch type for the fetch stage.
package if_pkg;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam int unsigned PC_RESET  = 0;
    localparam int unsigned NPC_RESET = 4;
    localparam int unsigned PC_STEP   = 4;

    // pc is held at 32 bits; the fetch unit supports ADDR_W up to 32.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Control/ID-side bundle of the fetch unit. IF_ANNUL_EN adds the annul input.
interface if_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
`ifdef IF_ANNUL_EN
    logic              annul;
`endif
    logic              LE;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              flush;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] npc_out;
    logic [31:0]       instruction_out;
    logic [ADDR_W-1:0] pc_id_out;
    logic              valid_id_out;
    logic              redir_pend_out;

    modport master (
`ifdef IF_ANNUL_EN
        output annul,
`endif
        output LE, redirect, redirect_target, flush, imem_we, imem_waddr, imem_wdata,
        input  pc_out, npc_out, instruction_out, pc_id_out, valid_id_out, redir_pend_out
    );

    modport slave (
`ifdef IF_ANNUL_EN
        input  annul,
`endif
        input  LE, redirect, redirect_target, flush, imem_we, imem_waddr, imem_wdata,
        output pc_out, npc_out, instruction_out, pc_id_out, valid_id_out, redir_pend_out
    );
endinterface

// File: rtl/if_fetch_unit_imem.sv
// Instruction memory: DEPTH x 32, asynchronous read, synchronous write, no reset.
module if_imem #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/if_fetch_unit.sv
// SPARC-style PC/nPC fetch stage with delayed-branch redirect, stall capture and IF/ID flush.
// Define IF_ANNUL_EN to add the annul input that squashes an untaken delay slot.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DEPTH    = 128,
    parameter logic [31:0] NOP_WORD = if_pkg::NOP_WORD
) (
    input logic          clk,
    input logic          R,
    if_fetch_unit_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_q, npc_q, ptgt_q, tgt;
    logic              pend_q, annul_slot;
    ifid_t             ifid_q;
    logic [31:0]       word;

    assign tgt = {bus.redirect_target[ADDR_W-1:2], 2'b00};

`ifdef IF_ANNUL_EN
    assign annul_slot = bus.annul & ~bus.redirect;
`else
    assign annul_slot = 1'b0;
`endif

    if_imem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_imem (
        .clk   (clk),
        .we    (bus.imem_we),
        .waddr (bus.imem_waddr[IDX_W+1:2]),
        .wdata (bus.imem_wdata),
        .raddr (pc_q[IDX_W+1:2]),
        .rdata (word)
    );

    always_ff @(posedge clk) begin
        if (R) begin
            pc_q   <= ADDR_W'(PC_RESET);
            npc_q  <= ADDR_W'(NPC_RESET);
            pend_q <= 1'b0;
            ptgt_q <= '0;
            ifid_q <= '{instr: NOP_WORD, pc: '0, valid: 1'b0};
        end else begin
            if (bus.LE) begin
                pc_q   <= npc_q;
                pend_q <= 1'b0;
                // A same-cycle redirect is newer than any captured one.
                if (bus.redirect)  npc_q <= tgt;
                else if (pend_q)   npc_q <= ptgt_q;
                else               npc_q <= npc_q + ADDR_W'(PC_STEP);
            end else if (bus.redirect) begin
                pend_q <= 1'b1;
                ptgt_q <= tgt;
            end

            if (bus.flush) begin
                ifid_q.instr <= NOP_WORD;
                ifid_q.valid <= 1'b0;
            end else if (bus.LE) begin
                ifid_q.instr <= annul_slot ? NOP_WORD : word;
                ifid_q.pc    <= 32'(pc_q);
                ifid_q.valid <= ~annul_slot;
            end
        end
    end

    assign bus.pc_out          = pc_q;
    assign bus.npc_out         = npc_q;
    assign bus.instruction_out = ifid_q.instr;
    assign bus.pc_id_out       = ADDR_W'(ifid_q.pc);
    assign bus.valid_id_out    = ifid_q.valid;
    assign bus.redir_pend_out  = pend_q;

    logic unused_bits;
    assign unused_bits = ^{bus.imem_waddr, bus.redirect_target[1:0], pc_q, ptgt_q[1:0]};
endmodule
